// File: rtl/reg_pipe_pkg.sv
// Shared limits and helpers for the reg_pipe register pipeline.
package reg_pipe_pkg;

  localparam int unsigned DEPTH_MAX = 16;
  localparam int unsigned WIDTH_MAX = 64;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline stage: valid flag, data register and its slice of the ready chain.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             clr,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_adv,
  output logic             adv,
  output logic             v,
  output logic [WIDTH-1:0] r
);

  // A stage may take a new word if it is empty or its occupant moves on this cycle.
  assign adv = ~v | down_adv;

  // Stage state: flush on reset/clear, otherwise advance; data only moves with a real word.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      r <= RESET_VAL;
    end else if (clr) begin
      v <= 1'b0;
      r <= RESET_VAL;
    end else if (adv) begin
      v <= up_valid;
      if (up_valid) begin
        r <= up_data;
      end
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Bubble-collapsing valid/ready register pipeline of DEPTH stages with occupancy count.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             q,
  output logic [occ_width(DEPTH)-1:0]  occ
);

  localparam int unsigned OccW = occ_width(DEPTH);

  // Elaboration-time guard on the supported parameter ranges.
  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("reg_pipe: DEPTH out of range");
  end
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("reg_pipe: WIDTH out of range");
  end

  // Stage chain; per-stage signals live in each generate scope so the ready chain
  // is a set of distinct nets rather than one self-referencing vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             down_adv;
    logic             adv;
    logic             v;
    logic [WIDTH-1:0] r;

    if (i == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = d;
    end else begin : g_mid
      assign up_valid = g_stage[i-1].v;
      assign up_data  = g_stage[i-1].r;
    end

    if (i == DEPTH - 1) begin : g_last
      assign down_adv = out_ready;
    end else begin : g_inner
      assign down_adv = g_stage[i+1].adv;
    end

    reg_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .ck       (ck),
      .rst      (rst),
      .clr      (clr),
      .up_valid (up_valid),
      .up_data  (up_data),
      .down_adv (down_adv),
      .adv      (adv),
      .v        (v),
      .r        (r)
    );
  end

  // A clear cycle refuses the input word since every stage is being flushed.
  assign in_ready  = g_stage[0].adv & ~clr;
  assign out_valid = g_stage[DEPTH-1].v;
  assign q         = g_stage[DEPTH-1].r;

  logic            push;
  logic            pop;
  logic [OccW-1:0] occ_q;
  logic [OccW-1:0] occ_d;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Occupancy next state; push/pop handshakes keep it within 0..DEPTH.
  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // Occupancy register, flushed together with the stages.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else if (clr) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL take parameter WIDTH, default 8, as the data width in bits (1..64).
REQ-002 SHALL take parameter DEPTH, default 4, as the number of register stages (1..16).
REQ-003 SHALL take parameter RESET_VAL, default 0, as the WIDTH-bit value loaded into every stage data register on reset or clear.
REQ-004 SHALL have port ck, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port clr, input, 1 bit: synchronous flush of all stages.
REQ-007 SHALL have port in_valid, input, 1 bit: d carries a word to accept.
REQ-008 SHALL have port in_ready, output, 1 bit: the pipe accepts d this cycle.
REQ-009 SHALL have port d, input, WIDTH bits: input data.
REQ-010 SHALL have port out_valid, output, 1 bit: q holds a valid word.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes q this cycle.
REQ-012 SHALL have port q, output, WIDTH bits: data of the last stage.
REQ-013 SHALL have port occ, output, clog2(DEPTH+1) bits: number of valid stages.

Function
REQ-014 SHALL hold, per stage i (0 = input, DEPTH-1 = output), a valid flag v[i] and a data register r[i].
REQ-015 SHALL define adv[DEPTH-1] = !v[DEPTH-1] | out_ready, and adv[i] = !v[i] | adv[i+1] for i < DEPTH-1 (bubble-collapsing, combinational ready chain).
REQ-016 SHALL drive in_ready = adv[0] & !clr.
REQ-017 SHALL, on each edge with clr=0 and adv[i]=1, load r[i] from the upstream source (d for i=0, else r[i-1]) and v[i] from the upstream valid (in_valid for i=0, else v[i-1]).
REQ-018 SHALL leave r[i] and v[i] unchanged when adv[i]=0.
REQ-019 SHALL leave r[i] unchanged when the incoming valid is 0, so that only v[i] clears (no toggling on bubbles).
REQ-020 SHALL drive q = r[DEPTH-1] and out_valid = v[DEPTH-1] directly from registers.
REQ-021 SHALL give a latency of exactly DEPTH cycles from an accepted word to out_valid when there are no stalls.
REQ-022 SHALL sustain a throughput of one word per cycle when out_ready is held at 1.
REQ-023 SHALL preserve the order of words; no word is dropped or duplicated.
REQ-024 SHALL fill a bubble ahead of a stalled stage when out_ready=0, so that the pipe compacts until all DEPTH stages are valid; in_ready=0 only when full and out_ready=0.
REQ-025 SHALL let a simultaneous accept and deliver on a full pipe with out_ready=1 succeed in the same cycle, leaving occ unchanged.
REQ-026 SHALL, when clr=1, clear all v[i] and set all r[i] to RESET_VAL at the next edge, with priority over any transfer; the input word in that cycle is not accepted (in_ready=0).
REQ-027 SHALL register occ, updated as occ + (in_valid & in_ready) - (out_valid & out_ready), or set to 0 on clr.
REQ-028 SHALL never let occ exceed DEPTH or underflow.

Reset
REQ-029 SHALL, while rst=1 and regardless of ck, force v[i]=0, r[i]=RESET_VAL and occ=0, giving out_valid=0 and q=RESET_VAL.
REQ-030 SHALL drive in_ready = out_ready-independent 1 during reset only if clr=0; words presented while rst=1 are discarded.
REQ-031 SHALL, when rst asserts mid-transfer, lose all in-flight words; the first edge after deassertion behaves as an empty pipe.

Structure
REQ-032 SHALL place DEPTH_MAX=16, WIDTH_MAX=64 and an occupancy-width function in shared package reg_pipe_pkg.
REQ-033 SHALL implement one stage (v, r, adv logic) as sub-module reg_pipe_stage, instantiated DEPTH times via generate.
REQ-034 SHALL use no latches, and combinational logic only for the adv chain and in_ready.

Verification
REQ-035 SHALL cover streaming: DEPTH=4, out_ready=1, in_valid=1 feeding d=1,2,3,... -> q=1 first valid 4 cycles after the first accept, then consecutive values every cycle.
REQ-036 SHALL cover full stall: out_ready=0, feed 6 words -> the first 4 are accepted, occ=4, in_ready=0; then out_ready=1 -> q emits 1,2,3,4 then 5,6 in order.
REQ-037 SHALL cover bubble collapse: one word then idle, out_ready=0 -> the word reaches stage 3 in 4 cycles, occ=1, in_ready stays 1.
REQ-038 SHALL cover clear: a full pipe with clr pulsed for 1 cycle -> next cycle out_valid=0, occ=0, q=RESET_VAL; the word presented with clr is absent from the output.
REQ-039 SHALL cover async reset: rst asserted between edges with occ=3 -> out_valid=0 and occ=0 immediately, before the next ck edge.
REQ-040 SHALL cover DEPTH=1, WIDTH=1: alternating out_ready with in_valid=1 -> no loss or duplication, scoreboard-checked.
